// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: PC, single-entry fetch/decode buffer, redirect and end-of-memory halt.
// Optional MIPS_FETCH_PERF_EN adds saturating fetch/stall counters.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned IMEM_AW    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  input  logic               ready_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               valid_o,
  output logic [31:0]        instr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  output logic               halt_o
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_out_q, pc_out_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;
  logic              halt_q, halt_d;
  logic              adv;
  logic              at_end;
  logic              unused_redirect_lsbs;

  assign adv    = !valid_q || ready_i;
  assign at_end = {2'b00, pc_q[XLEN-1:2]} >= XLEN'(IMEM_DEPTH);

  // Target byte offset is discarded; targets are forced word-aligned.
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign imem_addr_o = pc_q[IMEM_AW+1:2];
  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_out_q;
  assign pc_plus4_o  = pc_plus4_q;
  assign halt_o      = halt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
    end
  end

  // Redirect beats both advance and stall; the halt check only runs on an advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    unique case (state_q)
      BOOT: begin
        valid_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
          valid_d = 1'b0;
        end else if (adv) begin
          if (at_end) begin
            valid_d = 1'b0;
            halt_d  = 1'b1;
            state_d = HALT;
          end else begin
            instr_d    = imem_rdata_i;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + XLEN'(4);
            valid_d    = 1'b1;
            pc_d       = pc_q + XLEN'(4);
          end
        end
      end
      HALT: begin
        valid_d = 1'b0;
        halt_d  = 1'b1;
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

`ifdef MIPS_FETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  // Saturating counters of accepted instructions and stalled RUN cycles.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (valid_q && ready_i && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + XLEN'(1);
    end
    if ((state_q == RUN) && valid_q && !ready_i && !redirect_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit; memory word i holds 32'h1000_0000 + i.
module tb_mips_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halt;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mips_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(32),
    .IMEM_AW   (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .ready_i      (ready),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .valid_o      (valid),
    .instr_o      (instr),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .halt_o       (halt)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .fetch_cnt_o  (fetch_cnt),
    .stall_cnt_o  (stall_cnt)
`endif
  );

  assign imem_rdata = 32'h1000_0000 + 32'(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] exp_pc);
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".pc"}, pc, exp_pc);
    chk({tag, ".instr"}, instr, 32'h1000_0000 + (exp_pc >> 2));
    chk({tag, ".pc4"}, pc_plus4, exp_pc + 32'd4);
  endtask

  initial begin
    rst_n       = 1'b0;
    ready       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.halt", 32'(halt), 32'd0);
    chk("rst.instr", instr, 32'h0);
    chk("rst.pc", pc, 32'h0);
    chk("rst.pc4", pc_plus4, 32'h0);
    chk("rst.addr", 32'(imem_addr), 32'd0);

    // Release reset: one BOOT cycle, then one instruction per edge
    rst_n = 1'b1;
    step();
    chk("boot.valid", 32'(valid), 32'd0);
    step();
    chk_fetch("f0", 32'h0);
    step();
    chk_fetch("f1", 32'h4);
    step();
    chk_fetch("f2", 32'h8);
    chk("f2.addr", 32'(imem_addr), 32'd3);
`ifdef MIPS_FETCH_PERF_EN
    chk("perf.fetch0", fetch_cnt, 32'd2);
    chk("perf.stall0", stall_cnt, 32'd0);
`endif

    // Three-cycle stall holding pc_o=8
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_fetch("stall", 32'h8);
      chk("stall.addr", 32'(imem_addr), 32'd3);
    end
`ifdef MIPS_FETCH_PERF_EN
    chk("perf.stall3", stall_cnt, 32'd3);
    chk("perf.fetch_hold", fetch_cnt, 32'd2);
`endif
    ready = 1'b1;
    step();
    chk_fetch("release", 32'hC);

    // Reset for one edge while stalled
    ready = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rst2.valid", 32'(valid), 32'd0);
    chk("rst2.halt", 32'(halt), 32'd0);
    chk("rst2.pc", pc, 32'h0);
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    chk("boot2.valid", 32'(valid), 32'd0);
    step();
    chk_fetch("r0", 32'h0);
    step();
    chk_fetch("r1", 32'h4);

    // Redirect to unaligned 0x17 -> word 5
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0017;
    step();
    chk("redir.valid", 32'(valid), 32'd0);
    chk("redir.addr", 32'(imem_addr), 32'd5);
    redirect = 1'b0;
    step();
    chk_fetch("redir.tgt", 32'h14);

    // Redirect during a stall still flushes
    ready       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    chk("rs.valid", 32'(valid), 32'd0);
    redirect = 1'b0;
    ready    = 1'b1;
    step();
    chk_fetch("rs.tgt", 32'h40);

    // Run to the end of memory
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0078;
    step();
    chk("eom.flush", 32'(valid), 32'd0);
    redirect = 1'b0;
    step();
    chk_fetch("eom.78", 32'h78);
    step();
    chk_fetch("eom.7c", 32'h7C);
    step();
    chk("eom.valid", 32'(valid), 32'd0);
    chk("eom.halt", 32'(halt), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    step();
    chk("halt.redir.valid", 32'(valid), 32'd0);
    chk("halt.redir.halt", 32'(halt), 32'd1);
    redirect = 1'b0;

    // Redirect out of range: taken, then halt on the next edge
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk_fetch("oor.f0", 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    chk("oor.valid", 32'(valid), 32'd0);
    chk("oor.nohalt", 32'(halt), 32'd0);
    redirect = 1'b0;
    step();
    chk("oor.valid2", 32'(valid), 32'd0);
    chk("oor.halt", 32'(halt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the mips datapath. Holds the program counter and drives the word address to instruction memory. Registers the returned instruction and PC into a single-entry fetch/decode buffer with a valid/ready handshake. Handles branch/jump redirects from the datapath and halts cleanly at the end of instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
IMEM_DEPTH, 32, instruction memory depth in 32-bit words
IMEM_AW, 5, instruction memory word-address width; must satisfy 2**IMEM_AW >= IMEM_DEPTH

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
imem_addr_o  out  IMEM_AW  word address to instruction memory, = pc_q[IMEM_AW+1:2], combinational
imem_rdata_i  in  32  instruction word; combinational read of imem_addr_o
ready_i  in  1  downstream datapath accepts instr_o this cycle
redirect_i  in  1  branch/jump taken; load redirect_pc_i
redirect_pc_i  in  32  redirect target byte address
valid_o  out  1  instr_o/pc_o hold a valid fetched instruction
instr_o  out  32  fetched instruction
pc_o  out  32  byte address of instr_o
pc_plus4_o  out  32  pc_o + 4, modulo 2**32
halt_o  out  1  fetch has stopped at end of memory; sticky

Behaviour:
- Reset is synchronous only: rst_n=0 sampled at an edge sets pc_q=RESET_PC, valid_o=0, instr_o=0, pc_o=0, pc_plus4_o=0 (derived from pc_o), halt_o=0, state=BOOT. Reset mid-operation discards the buffered instruction.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after rst_n=1 is first sampled. valid_o stays 0; then go to RUN. The first instruction is therefore valid 2 edges after reset release.
- RUN, advance condition: adv = !valid_o || ready_i.
- On adv with no redirect: instr_o<=imem_rdata_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4.
- Stall: valid_o=1 and ready_i=0. All outputs and pc_q hold. imem_addr_o stays stable.
- Accept-without-refill is not allowed: if adv holds, the buffer always reloads in the same edge. This gives a throughput of 1 instr/cycle with ready_i held high.
- Redirect has priority over adv and stall: pc_q<={redirect_pc_i[31:2],2'b00} and valid_o<=0 (flush, regardless of ready_i). The first instruction from the target is valid one edge later, so redirect-to-valid latency is 2 edges.
- End of memory: the check is pc_q[31:2] >= IMEM_DEPTH in RUN with adv and no redirect. On that edge, load nothing and set valid_o<=0, halt_o<=1, state=HALT.
- A redirect to an out-of-range target is taken normally; the halt check applies on the following cycle.
- HALT: terminal until reset. redirect_i and ready_i are ignored; valid_o=0 and halt_o=1 are held.
- Arithmetic: pc_q+4 and pc_plus4_o wrap modulo 2**32 with no flag.
- Simultaneous redirect and ready_i in the same cycle: the buffered instruction counts as consumed, then the flush is applied.

Optional Feature:
Macro MIPS_FETCH_PERF_EN.
- When defined, adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0], both reset to 0.
- fetch_cnt_o increments on every edge where valid_o&&ready_i.
- stall_cnt_o increments on every edge where valid_o&&!ready_i&&!redirect_i in RUN.
- Both counters saturate at 32'hFFFF_FFFF.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, memory word i = 32'h1000_0000+i, ready_i=1: valid_o=0 for 1 cycle (BOOT), then pc_o=0,4,8… with instr_o=0x1000_0000,0x1000_0001,… on consecutive edges.
- Stall: ready_i=0 for 3 cycles while pc_o=8: instr_o=0x1000_0002 and pc_o=8 held, imem_addr_o=3 held; with PERF stall_cnt_o+=3; after release, next pc_o=12.
- Redirect: redirect_i=1 with redirect_pc_i=32'h0000_0017 while pc_o=4: next edge valid_o=0, then pc_o=0x14, instr_o=0x1000_0005.
- End of memory with IMEM_DEPTH=32, ready_i=1: last valid pc_o=0x7C; next edge valid_o=0, halt_o=1. A later redirect_i to 0 leaves halt_o=1, valid_o=0.
- Reset mid-stall: rst_n=0 for 1 edge while valid_o=1: valid_o=0, halt_o=0, pc restarts at RESET_PC after BOOT.
- Redirect and stall together: valid_o=1, ready_i=0, redirect_i=1: flush happens (valid_o=0 next edge) and target fetched following edge.
